serial_subtractor: RTL

- Bit-serial N-bit subtractor computing diff = a - b - bin, one bit per clock, LSB first.
- Built around a single full-subtractor cell and a registered borrow. It is the inverse (difference/borrow) counterpart of the team's ripple full-adder datapath.
- Sits as a low-area arithmetic unit behind a start/done handshake. Intended for compare/decrement paths where throughput of one result per W+1 cycles is acceptable.

---
 rtl/serial_arith_pkg.sv | 15 +
 rtl/full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 100 ++++++++++
 3 files changed

// File: rtl/serial_arith_pkg.sv
// Shared types and sizing helpers for the bit-serial arithmetic units.
package serial_arith_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // One extra bit so the counter can represent W-1 for every legal W, including W=1.
   function automatic int cnt_width(input int w);
      return $clog2(w) + 1;
   endfunction

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor: d = x - y - bin, with borrow-out.
module full_subtractor (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = x ^ y ^ bin;
   assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial W-bit subtractor, LSB first, one bit per clock behind a start/done handshake.
module serial_subtractor
   import serial_arith_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         bin,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] diff,
   output logic         bout,
   output logic         zero
);

   localparam int CW = cnt_width(W);

   state_t        r_state;
   state_t        w_next_state;
   logic [W-1:0]  r_a;
   logic [W-1:0]  r_b;
   logic          r_br;
   logic [CW-1:0] r_cnt;
   logic [W-1:0]  r_res;

   logic          w_accept;
   logic          w_last;
   logic          w_d;
   logic          w_bo;
   logic [W-1:0]  w_res_next;

   full_subtractor u_fs (
      .x    (r_a[0]),
      .y    (r_b[0]),
      .bin  (r_br),
      .d    (w_d),
      .bout (w_bo)
   );

   // Start is honoured in IDLE and in DONE (back-to-back), never while running.
   assign w_accept   = start && (r_state != ST_RUN);
   assign w_last     = (r_cnt == CW'(W - 1));
   assign w_res_next = (r_res >> 1) | (W'(w_d) << (W - 1));

   assign busy = (r_state == ST_RUN);
   assign done = (r_state == ST_DONE);

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: if (start) w_next_state = ST_RUN;
         ST_RUN:  if (w_last) w_next_state = ST_DONE;
         ST_DONE: w_next_state = start ? ST_RUN : ST_IDLE;
         default: w_next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a   <= '0;
         r_b   <= '0;
         r_br  <= 1'b0;
         r_cnt <= '0;
         r_res <= '0;
         diff  <= '0;
         bout  <= 1'b0;
         zero  <= 1'b0;
      end else if (w_accept) begin
         r_a   <= a;
         r_b   <= b;
         r_br  <= bin;
         r_cnt <= '0;
      end else if (r_state == ST_RUN) begin
         r_a   <= r_a >> 1;
         r_b   <= r_b >> 1;
         r_br  <= w_bo;
         r_cnt <= r_cnt + 1'b1;
         r_res <= w_res_next;
         // Results are published only on the edge that retires bit W-1.
         if (w_last) begin
            diff <= w_res_next;
            bout <= w_bo;
            zero <= (w_res_next == '0);
         end
      end
   end

endmodule
